// File: rtl/esi_beat_serializer_if.sv
// -----------------------------------------------------------------------------
// esi_beat_serializer_if
// Handshake bundle between the cosim data-out channel, the beat serializer and
// the DUT-side narrow ESI datapath.
//
// Parameters:
//   MSG_BITS  - width of one full ESI message
//   BEAT_BITS - width of one output beat
//
// Signals:
//   MsgInValid / MsgInReady / MsgIn        - wide message handshake (input side)
//   BeatOutValid / BeatOutReady / BeatOut  - narrow beat handshake (output side)
//   BeatOutFirst / BeatOutLast             - message framing markers
//   BeatOutIdx                             - index of the beat within its message
//
// Modports:
//   slave  - the serializer's view (consumes messages, produces beats)
//   master - the environment's view (produces messages, consumes beats)
// -----------------------------------------------------------------------------
interface esi_beat_serializer_if #(
   parameter int MSG_BITS  = 100,
   parameter int BEAT_BITS = 32
);
   localparam int NUM_BEATS = (MSG_BITS + BEAT_BITS - 1) / BEAT_BITS;
   localparam int IDX_BITS  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

   logic                 MsgInValid;
   logic                 MsgInReady;
   logic [MSG_BITS-1:0]  MsgIn;
   logic                 BeatOutValid;
   logic                 BeatOutReady;
   logic [BEAT_BITS-1:0] BeatOut;
   logic                 BeatOutFirst;
   logic                 BeatOutLast;
   logic [IDX_BITS-1:0]  BeatOutIdx;

   modport slave (
      input  MsgInValid, MsgIn, BeatOutReady,
      output MsgInReady, BeatOutValid, BeatOut, BeatOutFirst, BeatOutLast, BeatOutIdx
   );

   modport master (
      output MsgInValid, MsgIn, BeatOutReady,
      input  MsgInReady, BeatOutValid, BeatOut, BeatOutFirst, BeatOutLast, BeatOutIdx
   );
endinterface

// File: rtl/esi_beat_serializer.sv
// -----------------------------------------------------------------------------
// esi_beat_serializer
// Takes one wide ESI message per valid/ready handshake and presents it to the
// DUT as NUM_BEATS narrower beats, least-significant beat first, framed with
// first/last markers and a beat index. The final beat of one message and the
// acceptance of the next may share a cycle, so back-to-back messages stream
// without a bubble.
//
// Ports:
//   clk          - clock, all state changes on the rising edge
//   rstn         - synchronous reset, active-low
//   bus (slave)  - esi_beat_serializer_if handshake bundle
//   MsgCount     - (optional) accepted-message counter, wraps at 2^32
//   StallCycles  - (optional) cycles with BeatOutValid && !BeatOutReady
//
// Optional feature macro: ESI_BEAT_SERIALIZER_STATS_EN adds the two counters.
// -----------------------------------------------------------------------------
module esi_beat_serializer #(
   parameter int MSG_BITS  = 100,
   parameter int BEAT_BITS = 32
) (
   input  logic                       clk,
   input  logic                       rstn,
   esi_beat_serializer_if.slave       bus
`ifdef ESI_BEAT_SERIALIZER_STATS_EN
   ,
   output logic [31:0]                MsgCount,
   output logic [31:0]                StallCycles
`endif
);
   localparam int NUM_BEATS = (MSG_BITS + BEAT_BITS - 1) / BEAT_BITS;
   localparam int IDX_BITS  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam int HOLD_BITS = NUM_BEATS * BEAT_BITS;
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_BEATS - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   state_t                               state_r, state_n;
   logic [NUM_BEATS-1:0][BEAT_BITS-1:0]  hold_r, hold_n;
   logic [IDX_BITS-1:0]                  idx_r, idx_n;
   logic [BEAT_BITS-1:0]                 beat_r, beat_n;
   logic                                 first_r, first_n;
   logic                                 last_r, last_n;
   logic                                 valid_r, valid_n;

   logic [HOLD_BITS-1:0]                 msg_ext_s;
   logic [IDX_BITS-1:0]                  idx_inc_s;
   logic                                 xfer_s;
   logic                                 ready_s;
   logic                                 accept_s;

   // Zero-extend the incoming message so the last beat carries zeros above MSG_BITS.
   always_comb begin
      msg_ext_s                 = '0;
      msg_ext_s[MSG_BITS-1:0]   = bus.MsgIn;
   end

   assign xfer_s    = valid_r && bus.BeatOutReady;
   assign idx_inc_s = idx_r + IDX_BITS'(1);
   assign accept_s  = bus.MsgInValid && ready_s;

   // Accept when empty, or when the last beat leaves this very cycle.
   always_comb begin
      ready_s = 1'b0;
      case (state_r)
         ST_IDLE: ready_s = 1'b1;
         ST_SEND: ready_s = xfer_s && last_r;
         default: ready_s = 1'b0;
      endcase
   end

   // Next-state and next-beat logic; beat fields are precomputed so outputs come straight from flops.
   always_comb begin
      state_n = state_r;
      hold_n  = hold_r;
      idx_n   = idx_r;
      beat_n  = beat_r;
      first_n = first_r;
      last_n  = last_r;
      valid_n = valid_r;
      if (accept_s) begin
         state_n = ST_SEND;
         hold_n  = msg_ext_s;
         idx_n   = '0;
         beat_n  = msg_ext_s[BEAT_BITS-1:0];
         first_n = 1'b1;
         last_n  = (NUM_BEATS == 1);
         valid_n = 1'b1;
      end else if (xfer_s && last_r) begin
         state_n = ST_IDLE;
         valid_n = 1'b0;
      end else if (xfer_s) begin
         idx_n   = idx_inc_s;
         beat_n  = hold_r[idx_inc_s];
         first_n = 1'b0;
         last_n  = (idx_inc_s == LAST_IDX);
      end else begin
         state_n = state_r;
      end
   end

   // State and beat registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r <= ST_IDLE;
         hold_r  <= '0;
         idx_r   <= '0;
         beat_r  <= '0;
         first_r <= 1'b0;
         last_r  <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         state_r <= state_n;
         hold_r  <= hold_n;
         idx_r   <= idx_n;
         beat_r  <= beat_n;
         first_r <= first_n;
         last_r  <= last_n;
         valid_r <= valid_n;
      end
   end

   assign bus.MsgInReady   = ready_s;
   assign bus.BeatOutValid = valid_r;
   assign bus.BeatOut      = beat_r;
   assign bus.BeatOutFirst = first_r;
   assign bus.BeatOutLast  = last_r;
   assign bus.BeatOutIdx   = idx_r;

`ifdef ESI_BEAT_SERIALIZER_STATS_EN
   // Free-running statistics counters, wrapping modulo 2^32.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         MsgCount    <= 32'd0;
         StallCycles <= 32'd0;
      end else begin
         if (accept_s) begin
            MsgCount <= MsgCount + 32'd1;
         end else begin
            MsgCount <= MsgCount;
         end
         if (valid_r && !bus.BeatOutReady) begin
            StallCycles <= StallCycles + 32'd1;
         end else begin
            StallCycles <= StallCycles;
         end
      end
   end
`endif

endmodule

// File: tb/tb_esi_beat_serializer.sv
// -----------------------------------------------------------------------------
// tb_esi_beat_serializer
// Self-checking bench for esi_beat_serializer: a table of known messages with
// hand-derived beats, directed sequences for back-to-back, stall, reset and a
// single-beat configuration, then randomized traffic checked against a
// queue-based model of the expected beat stream.
// -----------------------------------------------------------------------------
module tb_esi_beat_serializer;
   localparam int MB = 100;
   localparam int BB = 32;
   localparam int NB = 4;

   logic clk;
   logic rstn;
   int   checks;
   int   failures;

   esi_beat_serializer_if #(.MSG_BITS(MB), .BEAT_BITS(BB)) bus ();
   esi_beat_serializer_if #(.MSG_BITS(8),  .BEAT_BITS(BB)) b8 ();

`ifdef ESI_BEAT_SERIALIZER_STATS_EN
   logic [31:0] msg_count, stall_cycles, msg_count8, stall_cycles8;
`endif

   esi_beat_serializer #(.MSG_BITS(MB), .BEAT_BITS(BB)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .bus         (bus)
`ifdef ESI_BEAT_SERIALIZER_STATS_EN
      ,
      .MsgCount    (msg_count),
      .StallCycles (stall_cycles)
`endif
   );

   esi_beat_serializer #(.MSG_BITS(8), .BEAT_BITS(BB)) dut8 (
      .clk         (clk),
      .rstn        (rstn),
      .bus         (b8)
`ifdef ESI_BEAT_SERIALIZER_STATS_EN
      ,
      .MsgCount    (msg_count8),
      .StallCycles (stall_cycles8)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [MB-1:0]         msg;
      logic [NB-1:0][BB-1:0] beats;
   } vec_t;

   typedef struct {
      logic [BB-1:0] beat;
      logic          first;
      logic          last;
      logic [1:0]    idx;
   } exp_beat_t;

   vec_t      vecs[5];
   exp_beat_t q[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_beat(input string name, input logic [BB-1:0] b, input int k);
      chk({name, ".valid"}, bus.BeatOutValid, 1'b1);
      chk({name, ".beat"},  bus.BeatOut, b);
      chk({name, ".first"}, bus.BeatOutFirst, (k == 0));
      chk({name, ".last"},  bus.BeatOutLast, (k == NB - 1));
      chk({name, ".idx"},   bus.BeatOutIdx, k[1:0]);
   endtask

   // Offer one table message with the sink always ready and check the 4 beats.
   task automatic run_vector(input int i);
      bus.MsgIn        = vecs[i].msg;
      bus.MsgInValid   = 1'b1;
      bus.BeatOutReady = 1'b1;
      settle();
      chk("vec.ready_idle", bus.MsgInReady, 1'b1);
      next_cycle();
      bus.MsgInValid = 1'b0;
      bus.MsgIn      = ~vecs[i].msg;
      settle();
      for (int k = 0; k < NB; k++) begin
         chk_beat("vec", vecs[i].beats[k], k);
         next_cycle();
         settle();
      end
      chk("vec.done_valid", bus.BeatOutValid, 1'b0);
   endtask

   initial begin
      logic [127:0] r;
      logic [127:0] t;
      logic [MB-1:0] m;
      logic          vi, br, exp_ready;
      exp_beat_t     e;

      checks   = 0;
      failures = 0;

      vecs[0].msg = 100'h9_ABCDEF01_23456789_DEADBEEF;
      vecs[0].beats = {32'h00000009, 32'hABCDEF01, 32'h23456789, 32'hDEADBEEF};
      vecs[1].msg = 100'hF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
      vecs[1].beats = {32'h0000000F, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      vecs[2].msg = 100'h1;
      vecs[2].beats = {32'h00000000, 32'h00000000, 32'h00000000, 32'h00000001};
      vecs[3].msg = 100'h8_00000000_00000000_00000000;
      vecs[3].beats = {32'h00000008, 32'h00000000, 32'h00000000, 32'h00000000};
      vecs[4].msg = 100'h0_12345678_9ABCDEF0_0F0F0F0F;
      vecs[4].beats = {32'h00000000, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F};

      rstn             = 1'b0;
      bus.MsgInValid   = 1'b0;
      bus.MsgIn        = '0;
      bus.BeatOutReady = 1'b0;
      b8.MsgInValid    = 1'b0;
      b8.MsgIn         = '0;
      b8.BeatOutReady  = 1'b1;
      next_cycle();
      next_cycle();
      settle();
      chk("rst.valid", bus.BeatOutValid, 1'b0);
      chk("rst.beat",  bus.BeatOut, 32'h0);
      chk("rst.first", bus.BeatOutFirst, 1'b0);
      chk("rst.last",  bus.BeatOutLast, 1'b0);
      chk("rst.idx",   bus.BeatOutIdx, 2'd0);
      rstn = 1'b1;
      next_cycle();
      settle();
      chk("rst.ready", bus.MsgInReady, 1'b1);

      // Stall for 5 cycles during beat 1 (first thing after reset, so counters start at 0).
      bus.MsgIn        = vecs[0].msg;
      bus.MsgInValid   = 1'b1;
      bus.BeatOutReady = 1'b1;
      next_cycle();
      bus.MsgInValid = 1'b0;
      settle();
      chk_beat("stall.b0", vecs[0].beats[0], 0);
      next_cycle();
      bus.BeatOutReady = 1'b0;
      settle();
      for (int s = 0; s < 5; s++) begin
         chk_beat("stall.hold", vecs[0].beats[1], 1);
         chk("stall.ready", bus.MsgInReady, 1'b0);
         next_cycle();
         settle();
      end
      bus.BeatOutReady = 1'b1;
      settle();
      chk_beat("stall.release", vecs[0].beats[1], 1);
`ifdef ESI_BEAT_SERIALIZER_STATS_EN
      chk("stats.stall", stall_cycles, 32'd5);
      chk("stats.msgs",  msg_count, 32'd1);
`endif
      for (int k = 2; k < NB; k++) begin
         next_cycle();
         settle();
         chk_beat("stall.tail", vecs[0].beats[k], k);
      end
      next_cycle();
      settle();
      chk("stall.done", bus.BeatOutValid, 1'b0);

      // Table of known messages.
      for (int i = 0; i < 5; i++) run_vector(i);

      // Back-to-back: 8 beats in 8 cycles, MsgInReady high in the beat-3 cycle.
      bus.MsgIn        = vecs[0].msg;
      bus.MsgInValid   = 1'b1;
      bus.BeatOutReady = 1'b1;
      next_cycle();
      bus.MsgIn = vecs[4].msg;
      settle();
      for (int k = 0; k < NB; k++) begin
         chk_beat("b2b.m1", vecs[0].beats[k], k);
         chk("b2b.ready", bus.MsgInReady, (k == NB - 1));
         next_cycle();
         if (k == NB - 1) begin
            bus.MsgInValid = 1'b0;
            bus.MsgIn      = '0;
         end
         settle();
      end
      for (int k = 0; k < NB; k++) begin
         chk_beat("b2b.m2", vecs[4].beats[k], k);
         next_cycle();
         settle();
      end
      chk("b2b.done", bus.BeatOutValid, 1'b0);

      // Reset asserted for one cycle during beat 2.
      bus.MsgIn      = vecs[1].msg;
      bus.MsgInValid = 1'b1;
      next_cycle();
      bus.MsgInValid = 1'b0;
      next_cycle();
      next_cycle();
      settle();
      chk("rmid.idx2", bus.BeatOutIdx, 2'd2);
      rstn = 1'b0;
      next_cycle();
      rstn = 1'b1;
      settle();
      chk("rmid.valid", bus.BeatOutValid, 1'b0);
      chk("rmid.ready", bus.MsgInReady, 1'b1);
      chk("rmid.beat",  bus.BeatOut, 32'h0);
      chk("rmid.idx",   bus.BeatOutIdx, 2'd0);
      chk("rmid.last",  bus.BeatOutLast, 1'b0);
      for (int s = 0; s < 3; s++) begin
         next_cycle();
         settle();
         chk("rmid.no_tail", bus.BeatOutValid, 1'b0);
      end
      run_vector(2);

      // Single-beat configuration: 8-bit message in a 32-bit beat.
      b8.MsgIn      = 8'hA5;
      b8.MsgInValid = 1'b1;
      settle();
      chk("one.ready_idle", b8.MsgInReady, 1'b1);
      next_cycle();
      b8.MsgIn = 8'h3C;
      settle();
      chk("one.valid", b8.BeatOutValid, 1'b1);
      chk("one.beat",  b8.BeatOut, 32'h000000A5);
      chk("one.first", b8.BeatOutFirst, 1'b1);
      chk("one.last",  b8.BeatOutLast, 1'b1);
      chk("one.idx",   b8.BeatOutIdx, 1'b0);
      chk("one.ready_b2b", b8.MsgInReady, 1'b1);
      next_cycle();
      b8.MsgInValid = 1'b0;
      settle();
      chk("one.beat2", b8.BeatOut, 32'h0000003C);
      chk("one.first2", b8.BeatOutFirst, 1'b1);
      chk("one.last2", b8.BeatOutLast, 1'b1);
      next_cycle();
      settle();
      chk("one.done", b8.BeatOutValid, 1'b0);

      // Randomized traffic against a queue of expected beats.
      q.delete();
      for (int c = 0; c < 2000; c++) begin
         vi = ($urandom_range(0, 9) < 6);
         br = ($urandom_range(0, 9) < 7);
         r  = {$urandom, $urandom, $urandom, $urandom};
         m  = r[MB-1:0];
         bus.MsgInValid   = vi;
         bus.MsgIn        = m;
         bus.BeatOutReady = br;
         settle();
         exp_ready = (q.size() == 0) || (q.size() == 1 && br);
         chk("rnd.valid", bus.BeatOutValid, (q.size() != 0));
         chk("rnd.ready", bus.MsgInReady, exp_ready);
         if (q.size() != 0) begin
            chk("rnd.beat",  bus.BeatOut, q[0].beat);
            chk("rnd.first", bus.BeatOutFirst, q[0].first);
            chk("rnd.last",  bus.BeatOutLast, q[0].last);
            chk("rnd.idx",   bus.BeatOutIdx, q[0].idx);
            if (br) void'(q.pop_front());
         end
         if (vi && exp_ready) begin
            for (int k = 0; k < NB; k++) begin
               t       = {28'h0, m} >> (k * BB);
               e.beat  = t[BB-1:0];
               e.first = (k == 0);
               e.last  = (k == NB - 1);
               e.idx   = 2'(k);
               q.push_back(e);
            end
         end
         next_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
